// File: rtl/adder4_pkg.sv
// Shared types and constants for the registered ripple-carry adder.
// Flag types exist only when ADDER4_FLAGS_EN is defined.
package adder4_pkg;

  localparam int ADDER4_WIDTH = 4;

  typedef struct packed {
    logic                    cout;
    logic [ADDER4_WIDTH-1:0] sum;
  } adder4_result_t;

`ifdef ADDER4_FLAGS_EN
  typedef struct packed {
    logic ovf;
    logic zero;
  } adder4_flags_t;
`endif

endpackage

// File: rtl/adder4_reg_full_adder_cell.sv
// One-bit full adder cell; purely combinational building block of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder4_reg.sv
// Registered WIDTH-bit ripple-carry adder with carry in/out and a valid qualifier.
// Optional signed-overflow and zero flags are enabled by defining ADDER4_FLAGS_EN.
module adder4_reg
  import adder4_pkg::*;
#(
  parameter int WIDTH = ADDER4_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef ADDER4_FLAGS_EN
  output logic             ovf,
  output logic             zero,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[gi]),
      .b  (b[gi]),
      .ci (carry[gi]),
      .s  (sum_comb[gi]),
      .co (carry[gi+1])
    );
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

`ifdef ADDER4_FLAGS_EN
  adder4_flags_t flags_q, flags_d;
`endif

  // Result registers only load on a valid input, so idle operands never reach the outputs.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
`ifdef ADDER4_FLAGS_EN
    flags_d     = flags_q;
`endif
    if (in_valid) begin
      sum_d  = sum_comb;
      cout_d = carry[WIDTH];
`ifdef ADDER4_FLAGS_EN
      flags_d.ovf  = carry[WIDTH] ^ carry[WIDTH-1];
      flags_d.zero = (sum_comb == '0);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ADDER4_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
`ifdef ADDER4_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
`ifdef ADDER4_FLAGS_EN
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;
`endif

endmodule

// File: tb/tb_adder4_reg.sv
// Directed self-checking bench for adder4_reg: reset, corner vectors, hold behaviour,
// mid-stream reset and an exhaustive back-to-back sweep of all operand combinations.
module tb_adder4_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       cin = 1'b0;
  logic [3:0] sum;
  logic       cout;
  logic       out_valid;
`ifdef ADDER4_FLAGS_EN
  logic       ovf;
  logic       zero;
`endif

  int n_vec = 0;
  int n_miscmp = 0;

  always #5 clk = ~clk;

  adder4_reg #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
`ifdef ADDER4_FLAGS_EN
    .ovf       (ovf),
    .zero      (zero),
`endif
    .out_valid (out_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_sum, input logic e_cout,
                           input logic e_valid);
    check({tag, ".sum"}, 32'(sum), 32'(e_sum));
    check({tag, ".cout"}, 32'(cout), 32'(e_cout));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
  endtask

  task automatic check_flags(input string tag, input logic e_ovf, input logic e_zero);
`ifdef ADDER4_FLAGS_EN
    check({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
    check({tag, ".zero"}, 32'(zero), 32'(e_zero));
`else
    if (e_ovf === 1'bx || e_zero === 1'bx) $display("flag expectation undefined for %s", tag);
`endif
  endtask

  initial begin
    logic [4:0] e_full;
    int         sa, sb, ssum;

    // Reset held two cycles with the heaviest operands presented.
    rst_n = 1'b0; in_valid = 1'b1; a = 4'hF; b = 4'hF; cin = 1'b1;
    step(); check_out("reset0", 4'h0, 1'b0, 1'b0); check_flags("reset0", 1'b0, 1'b0);
    step(); check_out("reset1", 4'h0, 1'b0, 1'b0); check_flags("reset1", 1'b0, 1'b0);

    // First edge out of reset captures the operands.
    rst_n = 1'b1; a = 4'h0; b = 4'h0; cin = 1'b0;
    step(); check_out("zero", 4'h0, 1'b0, 1'b1); check_flags("zero", 1'b0, 1'b1);

    a = 4'h3; b = 4'h5; cin = 1'b0;
    step(); check_out("nocarry", 4'h8, 1'b0, 1'b1); check_flags("nocarry", 1'b1, 1'b0);

    a = 4'h7; b = 4'h8; cin = 1'b1;
    step(); check_out("wrap", 4'h0, 1'b1, 1'b1); check_flags("wrap", 1'b0, 1'b1);

    a = 4'hF; b = 4'hF; cin = 1'b1;
    step(); check_out("allones", 4'hF, 1'b1, 1'b1); check_flags("allones", 1'b0, 1'b0);

    // Result must hold while idle operands churn.
    a = 4'h2; b = 4'h2; cin = 1'b0;
    step(); check_out("hold_load", 4'h4, 1'b0, 1'b1); check_flags("hold_load", 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); cin = 1'($urandom_range(0, 1));
      step(); check_out($sformatf("hold%0d", k), 4'h4, 1'b0, 1'b0);
      check_flags($sformatf("hold%0d", k), 1'b0, 1'b0);
    end

    // Reset in the middle of a valid stream.
    in_valid = 1'b1; a = 4'h9; b = 4'h6; cin = 1'b0;
    step(); check_out("stream", 4'hF, 1'b0, 1'b1);
    a = 4'h1; b = 4'h1; rst_n = 1'b0;
    step(); check_out("midreset", 4'h0, 1'b0, 1'b0); check_flags("midreset", 1'b0, 1'b0);
    rst_n = 1'b1; a = 4'hA; b = 4'h4; cin = 1'b1;
    step(); check_out("resume", 4'hF, 1'b0, 1'b1);

    // Exhaustive back-to-back sweep against an arithmetic golden model.
    for (int i = 0; i < 512; i++) begin
      a = i[8:5]; b = i[4:1]; cin = i[0];
      e_full = 5'(a) + 5'(b) + 5'(cin);
      sa = a[3] ? int'(a) - 16 : int'(a);
      sb = b[3] ? int'(b) - 16 : int'(b);
      ssum = sa + sb + int'(cin);
      step();
      check($sformatf("sweep a=%0h b=%0h c=%0d", a, b, cin), 32'({cout, sum}), 32'(e_full));
      check($sformatf("sweep_v a=%0h b=%0h c=%0d", a, b, cin), 32'(out_valid), 32'd1);
      check_flags($sformatf("sweep a=%0h b=%0h c=%0d", a, b, cin),
                  (ssum > 7) || (ssum < -8), e_full[3:0] == 4'h0);
    end

    in_valid = 1'b0;
    step(); check_out("drain", e_full[3:0], e_full[4], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
